// File: rtl/cruise_pkg.sv
// Shared definitions for the cruise-control mode sequencer.
//   state_t        : sequencer state codes, also driven out on the state port
//   CHG_UP/CHG_DN  : codes on the change button input
//   DEF_*          : default speed limits and timing constants
//   FULLY_ALERT    : alertness sample that ends drowsiness handling
//   clamp_speed()  : clamps a speed into [lo, hi]
package cruise_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_OFF      = 3'd0,
      ST_STANDBY  = 3'd1,
      ST_ACTIVE   = 3'd2,
      ST_OVERRIDE = 3'd3,
      ST_DROWSY   = 3'd4
   } state_t;

   localparam logic [1:0] CHG_UP = 2'b01;
   localparam logic [1:0] CHG_DN = 2'b10;

   localparam int DEF_MIN_SPEED     = 40;
   localparam int DEF_MAX_SPEED     = 200;
   localparam int DEF_STEP          = 5;
   localparam int DEF_RAMP_STEP     = 1;
   localparam int DEF_RAMP_DIV      = 4;
   localparam int DEF_DROWSY_CYCLES = 8;
   localparam int DEF_BRAKE_MARGIN  = 2;

   localparam logic [2:0] DEF_ALERT_MIN = 3'b100;
   localparam logic [2:0] FULLY_ALERT   = 3'b111;

   function automatic logic [7:0] clamp_speed(input logic [7:0] v,
                                              input logic [7:0] lo,
                                              input logic [7:0] hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/cruise_sequencer_if.sv
// Bundle between the driver-input side and the cruise sequencer.
//   master : driver side (buttons, pedal, alertness sensor, speed) and
//            consumer of the sequencer outputs
//   slave  : the sequencer itself
// Signalling: there is no valid/ready pairing. on_off and set_btn are
// single-cycle pulses; change, brake_pedal, hooshyari and speed are levels.
// All are sampled on every rising clock edge. Every output is registered
// and meaningful on every cycle.
interface cruise_sequencer_if;
   import cruise_pkg::*;

   logic               on_off;
   logic               set_btn;
   logic [1:0]         change;
   logic               brake_pedal;
   logic [2:0]         hooshyari;
   logic [7:0]         speed;
   logic [STATE_W-1:0] state;
   logic [7:0]         vset;
   logic [7:0]         vtarget;
   logic               engaged;
   logic               alarm;
   logic               tormoz_req;

   modport master (
      output on_off, set_btn, change, brake_pedal, hooshyari, speed,
      input  state, vset, vtarget, engaged, alarm, tormoz_req
   );

   modport slave (
      input  on_off, set_btn, change, brake_pedal, hooshyari, speed,
      output state, vset, vtarget, engaged, alarm, tormoz_req
   );

endinterface

// File: rtl/speed_ramp.sv
// Rate limiter for the target speed handed to the actuator datapath.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   enable       : ramp runs only while high (sequencer engaged)
//   load         : overwrite vtarget with load_val this edge
//   load_val     : value taken on load
//   vset         : speed vtarget converges on
//   vtarget      : ramped target speed
//   tick         : high on the clock where the ramp steps; shared with the
//                  sequencer so drowsy set-speed decay runs on the same cadence
module speed_ramp #(
   parameter int RAMP_STEP = 1,
   parameter int RAMP_DIV  = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic [7:0] vset,
   output logic [7:0] vtarget,
   output logic       tick
);

   localparam int            CW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(RAMP_DIV - 1);
   localparam logic [8:0]    STEP9    = 9'(RAMP_STEP);

   logic [CW-1:0] div_cnt;
   logic [8:0]    gap;
   logic [8:0]    delta;
   logic          rising;

   assign tick = enable && !load && (div_cnt == DIV_LAST);

   // Step is min(RAMP_STEP, |vset - vtarget|) so vtarget never overshoots.
   always_comb begin
      rising = (vset >= vtarget);
      gap    = rising ? ({1'b0, vset} - {1'b0, vtarget})
                      : ({1'b0, vtarget} - {1'b0, vset});
      delta  = (gap < STEP9) ? gap : STEP9;
   end

   // The divider restarts on a load and is held at zero while disabled,
   // so the first step always lands RAMP_DIV clocks after (re)engaging.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         vtarget <= '0;
      end else if (load) begin
         div_cnt <= '0;
         vtarget <= load_val;
      end else if (!enable) begin
         div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
         vtarget <= rising ? 8'({1'b0, vtarget} + delta)
                           : 8'({1'b0, vtarget} - delta);
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/cruise_sequencer.sv
// Cruise-control mode sequencer: engage / override / drowsiness handling,
// owner of the set-speed register and of the brake request.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : driver inputs (on_off, set_btn, change, brake_pedal,
//                  hooshyari, speed) and registered outputs (state, vset,
//                  vtarget, engaged, alarm, tormoz_req)
import cruise_pkg::*;

module cruise_sequencer #(
   parameter int         MIN_SPEED     = DEF_MIN_SPEED,
   parameter int         MAX_SPEED     = DEF_MAX_SPEED,
   parameter int         STEP          = DEF_STEP,
   parameter int         RAMP_STEP     = DEF_RAMP_STEP,
   parameter int         RAMP_DIV      = DEF_RAMP_DIV,
   parameter logic [2:0] ALERT_MIN     = DEF_ALERT_MIN,
   parameter int         DROWSY_CYCLES = DEF_DROWSY_CYCLES,
   parameter int         BRAKE_MARGIN  = DEF_BRAKE_MARGIN
) (
   input logic             clock,
   input logic             reset,
   cruise_sequencer_if.slave bus
);

   localparam logic [7:0] MIN8    = 8'(MIN_SPEED);
   localparam logic [7:0] MAX8    = 8'(MAX_SPEED);
   localparam logic [8:0] MIN9    = 9'(MIN_SPEED);
   localparam logic [8:0] MAX9    = 9'(MAX_SPEED);
   localparam logic [8:0] STEP9   = 9'(STEP);
   localparam logic [8:0] MARGIN9 = 9'(BRAKE_MARGIN);

   localparam int             DCW         = $clog2(DROWSY_CYCLES + 1);
   localparam logic [DCW-1:0] DROWSY_LAST = DCW'(DROWSY_CYCLES - 1);
   localparam logic [DCW-1:0] DROWSY_SAT  = DCW'(DROWSY_CYCLES);

   state_t         st, st_nx;
   logic [7:0]     vset_r, vset_nx;
   logic           engaged_r, alarm_r, tormoz_r;
   logic [1:0]     chg_prev;
   logic [DCW-1:0] drowsy_cnt, cnt_nx;

   logic [7:0] vtarget_w;
   logic       tick_w;
   logic       ramp_load;
   logic [7:0] ramp_val;

   logic [8:0] vset9, vset_up9;
   logic [7:0] vset_up, vset_dn;
   logic       in_range, drowsy_now, drowsy_timeout;
   logic       up_edge, dn_edge, set_go;

   // Event decode shared by the next-state logic and the ramp load.
   always_comb begin
      vset9          = {1'b0, vset_r};
      vset_up9       = vset9 + STEP9;
      vset_up        = (vset_up9 > MAX9) ? MAX8 : vset_up9[7:0];
      vset_dn        = (vset9 < MIN9 + STEP9) ? MIN8 : 8'(vset9 - STEP9);
      in_range       = (bus.speed >= MIN8) && (bus.speed <= MAX8);
      drowsy_now     = (bus.hooshyari < ALERT_MIN);
      drowsy_timeout = (st == ST_ACTIVE) && drowsy_now && (drowsy_cnt >= DROWSY_LAST);
      // One step per press: act only on the clock the button code changes.
      up_edge        = (bus.change != chg_prev) && (bus.change == CHG_UP);
      dn_edge        = (bus.change != chg_prev) && (bus.change == CHG_DN);
      // A held brake outranks set/resume in every state.
      set_go         = bus.set_btn && !bus.brake_pedal;
   end

   // Next state in priority order: on_off, brake, drowsy timeout, set, change.
   always_comb begin
      st_nx     = st;
      vset_nx   = vset_r;
      cnt_nx    = '0;
      ramp_load = 1'b0;
      ramp_val  = bus.speed;
      if (bus.on_off) begin
         if (st == ST_OFF) begin
            st_nx = ST_STANDBY;
         end else begin
            st_nx     = ST_OFF;
            vset_nx   = '0;
            ramp_load = 1'b1;
            ramp_val  = '0;
         end
      end else begin
         case (st)
            ST_OFF: ;
            ST_STANDBY: begin
               if (set_go && in_range) begin
                  st_nx     = ST_ACTIVE;
                  vset_nx   = bus.speed;
                  ramp_load = 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (bus.brake_pedal) begin
                  st_nx = ST_OVERRIDE;
               end else if (drowsy_timeout) begin
                  st_nx = ST_DROWSY;
               end else begin
                  if (drowsy_now)
                     cnt_nx = (drowsy_cnt == DROWSY_SAT) ? drowsy_cnt : drowsy_cnt + 1'b1;
                  if (bus.set_btn && in_range) begin
                     vset_nx   = bus.speed;
                     ramp_load = 1'b1;
                  end else if (up_edge) begin
                     vset_nx = vset_up;
                  end else if (dn_edge) begin
                     vset_nx = vset_dn;
                  end
               end
            end
            ST_OVERRIDE: begin
               // Resume keeps the remembered vset; vtarget restarts from
               // the current (clamped) speed and ramps back up to it.
               if (set_go && (vset_r != '0)) begin
                  st_nx     = ST_ACTIVE;
                  ramp_load = 1'b1;
                  ramp_val  = clamp_speed(bus.speed, MIN8, MAX8);
               end
            end
            ST_DROWSY: begin
               if (bus.brake_pedal)
                  st_nx = ST_OVERRIDE;
               else if (bus.hooshyari == FULLY_ALERT)
                  st_nx = ST_ACTIVE;
               else if (tick_w)
                  vset_nx = vset_dn;
            end
            default: st_nx = ST_OFF;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         st         <= ST_OFF;
         vset_r     <= '0;
         engaged_r  <= 1'b0;
         alarm_r    <= 1'b0;
         tormoz_r   <= 1'b0;
         chg_prev   <= '0;
         drowsy_cnt <= '0;
      end else begin
         st         <= st_nx;
         vset_r     <= vset_nx;
         engaged_r  <= (st_nx == ST_ACTIVE) || (st_nx == ST_DROWSY);
         alarm_r    <= (st_nx == ST_DROWSY);
         chg_prev   <= bus.change;
         drowsy_cnt <= cnt_nx;
         tormoz_r   <= engaged_r && ({1'b0, bus.speed} > ({1'b0, vtarget_w} + MARGIN9));
      end
   end

   speed_ramp #(
      .RAMP_STEP (RAMP_STEP),
      .RAMP_DIV  (RAMP_DIV)
   ) u_ramp (
      .clock    (clock),
      .reset    (reset),
      .enable   (engaged_r),
      .load     (ramp_load),
      .load_val (ramp_val),
      .vset     (vset_r),
      .vtarget  (vtarget_w),
      .tick     (tick_w)
   );

   assign bus.state      = st;
   assign bus.vset       = vset_r;
   assign bus.vtarget    = vtarget_w;
   assign bus.engaged    = engaged_r;
   assign bus.alarm      = alarm_r;
   assign bus.tormoz_req = tormoz_r;

endmodule
